// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-channel and RAM signal bundle for mem_arbiter
// The arbiter takes the slave view; the cache/RAM environment takes the master view.
interface mem_arbiter_if #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*WORD_W-1:0] iaddr;
  logic [CPUS*WORD_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   err;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, err
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of per-channel I/D requests onto one RAM port
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int CPUS    = 2,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state, w_next;
  logic [IW-1:0]     r_rr, r_gnt, w_win, w_rr_next;
  logic              r_is_d, r_wr;
  logic [WORD_W-1:0] r_addr, r_store, r_load;
  logic              w_any, w_win_d, w_win_wr, w_timeout;
  logic [CPUS-1:0]   w_dreq;
  logic [WORD_W-1:0] w_win_addr, w_win_store;

  assign w_dreq    = bus.dREN | bus.dWEN;
  assign w_rr_next = IW'((int'(r_gnt) + 1) % CPUS);

  // First requesting channel at or after r_rr, wrapping
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < CPUS; i++) begin
      if (!w_any && (w_dreq[(int'(r_rr) + i) % CPUS] || bus.iREN[(int'(r_rr) + i) % CPUS])) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_rr) + i) % CPUS);
      end
    end
  end

  always_comb begin
    w_win_d     = w_dreq[w_win];
    w_win_wr    = w_win_d && bus.dWEN[w_win];
    w_win_addr  = w_win_d ? bus.daddr[int'(w_win)*WORD_W +: WORD_W]
                          : bus.iaddr[int'(w_win)*WORD_W +: WORD_W];
    w_win_store = w_win_wr ? bus.dstore[int'(w_win)*WORD_W +: WORD_W] : '0;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign bus.err   = r_err;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ACCESS) && (bus.ramstate != RAM_ACCESS) && w_timeout;
      if (r_state == ACCESS) r_cnt <= r_cnt + CW'(1);
      else                   r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (nRST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  if (bus.ramstate == RAM_ACCESS) w_next = DONE;
               else if (w_timeout)            w_next = IDLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_rr    <= '0;
      r_gnt   <= '0;
      r_is_d  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
      r_load  <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_gnt   <= w_win;
        r_is_d  <= w_win_d;
        r_wr    <= w_win_wr;
        r_addr  <= w_win_addr;
        r_store <= w_win_store;
      end
      // Read data is captured when RAM acknowledges, then presented in DONE
      if (r_state == ACCESS && bus.ramstate == RAM_ACCESS) r_load <= bus.ramload;
      if (r_state == DONE || (r_state == ACCESS && w_next == IDLE)) r_rr <= w_rr_next;
    end
  end

  always_comb begin
    bus.ramREN   = (r_state == ACCESS) && !r_wr;
    bus.ramWEN   = (r_state == ACCESS) && r_wr;
    bus.ramaddr  = r_addr;
    bus.ramstore = r_store;
    bus.iwait    = '0;
    bus.dwait    = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    for (int k = 0; k < CPUS; k++) begin
      bus.iwait[k] = bus.iREN[k] && !(r_state == DONE && int'(r_gnt) == k && !r_is_d);
      bus.dwait[k] = w_dreq[k]   && !(r_state == DONE && int'(r_gnt) == k && r_is_d);
      if (r_state == DONE && int'(r_gnt) == k && !r_wr) begin
        if (r_is_d) bus.dload[k*WORD_W +: WORD_W] = r_load;
        else        bus.iload[k*WORD_W +: WORD_W] = r_load;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.CPUS(2), .WORD_W(32)) bus();

  mem_arbiter #(.CPUS(2), .WORD_W(32), .TIMEOUT(8)) dut (
    .CLK  (clk),
    .nRST (rst),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", bus.ramREN, bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin errors++; $display("FAIL reset_ram_bus got=%h/%h exp=0/0", bus.ramaddr, bus.ramstore); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.iload !== 64'h0 || bus.dload !== 64'h0) begin errors++; $display("FAIL reset_loads got=%h/%h exp=0/0", bus.iload, bus.dload); end
    checks++; if (bus.iwait !== 2'b00 || bus.dwait !== 2'b00) begin errors++; $display("FAIL reset_waits got=%b/%b exp=00/00", bus.iwait, bus.dwait); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bus.dREN = 2'b01; bus.daddr = {32'h0, 32'h40};
    bus.ramstate = ACC; bus.ramload = 32'hDEADBEEF;
    #1;
    checks++; if (bus.dwait !== 2'b01) begin errors++; $display("FAIL read_idle_wait got=%b exp=01", bus.dwait); end
    step();
    checks++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40) begin errors++; $display("FAIL read_access got=%b%b %h exp=10 00000040", bus.ramREN, bus.ramWEN, bus.ramaddr); end
    checks++; if (bus.dwait !== 2'b01) begin errors++; $display("FAIL read_access_wait got=%b exp=01", bus.dwait); end
    step();
    checks++; if (bus.dwait !== 2'b00) begin errors++; $display("FAIL read_done_wait got=%b exp=00", bus.dwait); end
    checks++; if (bus.dload !== {32'h0, 32'hDEADBEEF}) begin errors++; $display("FAIL read_done_dload got=%h exp=00000000deadbeef", bus.dload); end
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL read_done_strobe got=%b exp=0", bus.ramREN); end
    bus.dREN = 2'b00; bus.ramstate = FREE;
    step();
    checks++; if (bus.dload !== 64'h0 || bus.dwait !== 2'b00) begin errors++; $display("FAIL read_after got=%h %b exp=0 00", bus.dload, bus.dwait); end
  endtask

  task automatic test_contention();
    rst = 1'b1; step(); rst = 1'b0;
    bus.dREN = 2'b11; bus.daddr = {32'h200, 32'h100}; bus.ramstate = ACC;
    for (int g = 0; g < 4; g++) begin
      bus.ramload = 32'hC0DE0000 + g;
      step();
      checks++; if (bus.ramaddr !== ((g % 2 == 0) ? 32'h100 : 32'h200)) begin errors++; $display("FAIL rr_addr[%0d] got=%h exp=%h", g, bus.ramaddr, (g % 2 == 0) ? 32'h100 : 32'h200); end
      step();
      checks++; if (bus.dwait !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", g, bus.dwait, (g % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (bus.dload !== ((g % 2 == 0) ? {32'h0, 32'hC0DE0000 + g} : {32'hC0DE0000 + g, 32'h0})) begin errors++; $display("FAIL rr_load[%0d] got=%h", g, bus.dload); end
      step();
    end
    bus.dREN = 2'b00; bus.ramstate = FREE;
    step();
  endtask

  task automatic test_priority();
    bus.iREN = 2'b10; bus.dWEN = 2'b10; bus.dREN = 2'b10;
    bus.daddr = {32'h80, 32'h0}; bus.dstore = {32'h12345678, 32'h0};
    bus.iaddr = {32'h300, 32'h0}; bus.ramstate = ACC; bus.ramload = 32'h0BADF00D;
    step();
    checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL prio_wen got=%b%b exp=01", bus.ramREN, bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h80 || bus.ramstore !== 32'h12345678) begin errors++; $display("FAIL prio_wr_bus got=%h/%h exp=80/12345678", bus.ramaddr, bus.ramstore); end
    step();
    checks++; if (bus.dwait !== 2'b00 || bus.iwait !== 2'b10) begin errors++; $display("FAIL prio_wr_done got=%b/%b exp=00/10", bus.dwait, bus.iwait); end
    checks++; if (bus.dload !== 64'h0) begin errors++; $display("FAIL prio_wr_load got=%h exp=0", bus.dload); end
    bus.dWEN = 2'b00; bus.dREN = 2'b00;
    step();
    checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL prio_idle_iwait got=%b exp=10", bus.iwait); end
    step();
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h300 || bus.ramstore !== 32'h0) begin errors++; $display("FAIL prio_ird got=%b %h %h exp=1 300 0", bus.ramREN, bus.ramaddr, bus.ramstore); end
    step();
    checks++; if (bus.iwait !== 2'b00 || bus.iload !== {32'h0BADF00D, 32'h0}) begin errors++; $display("FAIL prio_ird_done got=%b %h", bus.iwait, bus.iload); end
    bus.iREN = 2'b00; bus.ramstate = FREE;
    step();
  endtask

  task automatic test_wait_states();
    bus.dREN = 2'b01; bus.daddr = {32'h0, 32'h44}; bus.ramstate = BUSY; bus.ramload = 32'h5A5A1234;
    for (int c = 2; c <= 7; c++) begin
      step();
      bus.ramstate = (c <= 5) ? BUSY : ((c == 6) ? ERR : ACC);
      checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44 || bus.dwait !== 2'b01) begin errors++; $display("FAIL ws_cycle%0d got=%b %h %b exp=1 44 01", c, bus.ramREN, bus.ramaddr, bus.dwait); end
    end
    step();
    checks++; if (bus.dwait !== 2'b00 || bus.dload !== {32'h0, 32'h5A5A1234}) begin errors++; $display("FAIL ws_done got=%b %h", bus.dwait, bus.dload); end
    bus.dREN = 2'b00; bus.ramstate = FREE;
    step();
  endtask

  task automatic test_reset_mid_access();
    bus.dREN = 2'b11; bus.daddr = {32'h220, 32'h110}; bus.ramstate = BUSY;
    step();
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h220) begin errors++; $display("FAIL rst_mid_pre got=%b %h exp=1 220", bus.ramREN, bus.ramaddr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got=%b %h %b exp=0 0 0", bus.ramREN, bus.ramaddr, bus.err); end
    checks++; if (bus.dwait !== 2'b11) begin errors++; $display("FAIL rst_mid_wait got=%b exp=11", bus.dwait); end
    bus.ramstate = ACC;
    step();
    checks++; if (bus.ramaddr !== 32'h110) begin errors++; $display("FAIL rst_mid_rr got=%h exp=110", bus.ramaddr); end
    step();
    checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL rst_mid_done got=%b exp=10", bus.dwait); end
    bus.dREN = 2'b00; bus.ramstate = FREE;
    step();
  endtask

  task automatic test_timeout();
    bus.dREN = 2'b01; bus.daddr = {32'h0, 32'h90}; bus.ramstate = BUSY;
    step();
    for (int c = 1; c <= 8; c++) begin
      checks++; if (bus.err !== 1'b0 || bus.ramREN !== 1'b1) begin errors++; $display("FAIL to_access%0d got=%b %b exp=0 1", c, bus.err, bus.ramREN); end
      if (c < 8) step();
    end
    step();
`ifdef ARB_TIMEOUT_EN
    checks++; if (bus.err !== 1'b1 || bus.ramREN !== 1'b0 || bus.dwait !== 2'b01) begin errors++; $display("FAIL to_abort got=%b %b %b exp=1 0 01", bus.err, bus.ramREN, bus.dwait); end
    step();
    checks++; if (bus.err !== 1'b0 || bus.ramREN !== 1'b1) begin errors++; $display("FAIL to_once got=%b %b exp=0 1", bus.err, bus.ramREN); end
`else
    checks++; if (bus.err !== 1'b0 || bus.ramREN !== 1'b1 || bus.dwait !== 2'b01) begin errors++; $display("FAIL noto_hold got=%b %b %b exp=0 1 01", bus.err, bus.ramREN, bus.dwait); end
`endif
    bus.dREN = 2'b00;
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_priority();
    test_wait_states();
    test_reset_mid_access();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
